// File: rtl/uart_tx_serializer.sv
// UART transmitter with a small transmit FIFO.
// Accepts bytes on a valid/ready handshake and buffers them. Frames are sent as
// 1 start bit, DATA_BITS data bits MSB first, then 1 stop bit. Back-to-back
// frames follow each other with no idle cycle between them.
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous active-high reset
//   tx_data    - byte to send, sampled when tx_valid & tx_ready
//   tx_valid   - tx_data holds a valid byte
//   tx_ready   - FIFO can accept a byte (not full)
//   uart_tx    - serial line, idle high, driven from a flop
//   busy       - frame in progress or FIFO non-empty
//   tx_done    - one-cycle pulse on the last cycle of each stop bit
//   fifo_count - number of bytes buffered and not yet popped
module uart_tx_serializer #(
  parameter int unsigned CLKS_PER_BIT = 234,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS) + 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 uart_tx_q, uart_tx_d;
  logic                 tx_done_q, tx_done_d;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q, count_d;

  logic push;
  logic pop;
  logic fifo_empty;
  logic baud_last;

  // Handshake and FIFO status
  assign fifo_empty = (count_q == '0);
  assign tx_ready   = (count_q != CNT_FULL);
  assign push       = tx_valid & tx_ready;
  assign baud_last  = (baud_q == BAUD_LAST);

  assign uart_tx    = uart_tx_q;
  assign tx_done    = tx_done_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != ST_IDLE) | (count_q != '0);

  // Next-state, pop decision and registered-output lookahead
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = shift_q << 1;
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == BIT_LAST) begin
            state_d = ST_STOP;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          // Chain straight into the next start bit when a byte is waiting
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Line level and done pulse are derived from the next state so both come from flops
    unique case (state_d)
      ST_START: uart_tx_d = 1'b0;
      ST_DATA:  uart_tx_d = shift_d[DATA_BITS-1];
      default:  uart_tx_d = 1'b1;
    endcase
    tx_done_d = (state_d == ST_STOP) && (baud_d == BAUD_LAST);

    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // State, counters, line flop and FIFO pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      uart_tx_q <= 1'b1;
      tx_done_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      uart_tx_q <= uart_tx_d;
      tx_done_q <= tx_done_d;
      count_q   <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // FIFO storage; contents need no reset since the count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

endmodule
